// File: rtl/sbox_layer_ctrl_d4_if.sv
// ---------------------------------------------------------------------------
// sbox_layer_ctrl_d4_if
//   Link between the S-box layer controller and one external 5-share masked
//   4-bit S-box (order-4 HPC2).
//
//   sbox_in_s0..s4   4 bit   controller -> S-box, one share each
//   sbox_fresh      40 bit   controller -> S-box, fresh randomness
//   sbox_out_s0..s4  4 bit   S-box -> controller, one share each
//
//   modport master : controller side
//   modport slave  : S-box side
// ---------------------------------------------------------------------------
interface sbox_layer_ctrl_d4_if;
  logic [3:0]  sbox_in_s0;
  logic [3:0]  sbox_in_s1;
  logic [3:0]  sbox_in_s2;
  logic [3:0]  sbox_in_s3;
  logic [3:0]  sbox_in_s4;
  logic [39:0] sbox_fresh;
  logic [3:0]  sbox_out_s0;
  logic [3:0]  sbox_out_s1;
  logic [3:0]  sbox_out_s2;
  logic [3:0]  sbox_out_s3;
  logic [3:0]  sbox_out_s4;

  modport master (
    output sbox_in_s0, sbox_in_s1, sbox_in_s2, sbox_in_s3, sbox_in_s4,
    output sbox_fresh,
    input  sbox_out_s0, sbox_out_s1, sbox_out_s2, sbox_out_s3, sbox_out_s4
  );

  modport slave (
    input  sbox_in_s0, sbox_in_s1, sbox_in_s2, sbox_in_s3, sbox_in_s4,
    input  sbox_fresh,
    output sbox_out_s0, sbox_out_s1, sbox_out_s2, sbox_out_s3, sbox_out_s4
  );
endinterface

// File: rtl/sbox_layer_ctrl_d4.sv
// ---------------------------------------------------------------------------
// sbox_layer_ctrl_d4
//   Streams the nibbles of a 5-share masked state through one external
//   masked S-box, one nibble per cycle, and collects the S-box output shares
//   back into a 5-share result state. Shares are handled strictly share by
//   share; they are never combined.
//
//   Parameters
//     LATENCY  S-box latency in clock edges (input presented -> output valid)
//     NIBBLES  4-bit nibbles per state (at most 32)
//
//   Ports
//     clk                 clock, rising edge
//     rst                 asynchronous reset, active low
//     start               request to process a state, sampled only when idle
//     state_s0..s4        input state shares, nibble k = bits [4k+3:4k]
//     rnd_in              fresh randomness, forwarded during feed cycles
//     sbox                master side of the S-box link
//     result_s0..s4       substituted state shares, same nibble order
//     busy                high while a state is in flight
//     done                one-cycle pulse when result_s* is complete
// ---------------------------------------------------------------------------
module sbox_layer_ctrl_d4 #(
  parameter int LATENCY = 4,
  parameter int NIBBLES = 16
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [4*NIBBLES-1:0]  state_s0,
  input  logic [4*NIBBLES-1:0]  state_s1,
  input  logic [4*NIBBLES-1:0]  state_s2,
  input  logic [4*NIBBLES-1:0]  state_s3,
  input  logic [4*NIBBLES-1:0]  state_s4,
  input  logic [39:0]           rnd_in,
  sbox_layer_ctrl_d4_if.master  sbox,
  output logic [4*NIBBLES-1:0]  result_s0,
  output logic [4*NIBBLES-1:0]  result_s1,
  output logic [4*NIBBLES-1:0]  result_s2,
  output logic [4*NIBBLES-1:0]  result_s3,
  output logic [4*NIBBLES-1:0]  result_s4,
  output logic                  busy,
  output logic                  done
);

  localparam int         SHARES   = 5;
  localparam int         W        = 4 * NIBBLES;
  localparam logic [4:0] LAST_IDX = 5'(NIBBLES - 1);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FEED  = 2'd1,
    DRAIN = 2'd2
  } fsm_t;

  fsm_t        state_q;
  fsm_t        state_d;

  logic [4:0]  cnt_q;                 // nibble currently being fed
  logic [W-1:0] shift_q  [SHARES];    // loaded shares, shifted one nibble per feed cycle
  logic [W-1:0] res_q    [SHARES];    // collected output shares
  logic [W-1:0] share_in [SHARES];
  logic [3:0]   box_out  [SHARES];
  logic         pv_q     [LATENCY];   // nibble in flight inside the S-box
  logic [4:0]   pidx_q   [LATENCY];   // which nibble that is

  logic accept;
  logic feeding;
  logic feed_last;
  logic cap_last;

  assign share_in[0] = state_s0;
  assign share_in[1] = state_s1;
  assign share_in[2] = state_s2;
  assign share_in[3] = state_s3;
  assign share_in[4] = state_s4;

  assign box_out[0] = sbox.sbox_out_s0;
  assign box_out[1] = sbox.sbox_out_s1;
  assign box_out[2] = sbox.sbox_out_s2;
  assign box_out[3] = sbox.sbox_out_s3;
  assign box_out[4] = sbox.sbox_out_s4;

  assign feeding   = (state_q == FEED);
  assign feed_last = feeding && (cnt_q == LAST_IDX);
  // The last nibble leaving the S-box pipeline ends the operation.
  assign cap_last  = pv_q[LATENCY-1] && (pidx_q[LATENCY-1] == LAST_IDX);

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of process ordering.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  // NOTE: every output of this block is defaulted first so no path can
  // leave a value unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          accept  = 1'b1;
          state_d = FEED;
        end
      end
      FEED: begin
        if (feed_last) state_d = DRAIN;
      end
      DRAIN: begin
        if (cap_last) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // ---------------------------------------------------------------------
  // Datapath: feed counter, share shift registers, tracking pipeline,
  // result collection
  // ---------------------------------------------------------------------
  // NOTE: the share and result arrays are reset explicitly; an aborted run
  // must not leave partial shares visible on result_s*.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
      done  <= 1'b0;
      for (int s = 0; s < SHARES; s++) begin
        shift_q[s] <= '0;
        res_q[s]   <= '0;
      end
      for (int k = 0; k < LATENCY; k++) begin
        pv_q[k]   <= 1'b0;
        pidx_q[k] <= '0;
      end
    end else begin
      done <= (state_q == DRAIN) && cap_last;

      // Valid/index pipeline mirrors the S-box latency.
      pv_q[0]   <= feeding;
      pidx_q[0] <= cnt_q;
      for (int k = 1; k < LATENCY; k++) begin
        pv_q[k]   <= pv_q[k-1];
        pidx_q[k] <= pidx_q[k-1];
      end

      // Capture each share into its own result register.
      if (pv_q[LATENCY-1]) begin
        for (int s = 0; s < SHARES; s++) begin
          res_q[s][4*pidx_q[LATENCY-1] +: 4] <= box_out[s];
        end
      end

      if (feeding) begin
        cnt_q <= feed_last ? 5'd0 : cnt_q + 5'd1;
        for (int s = 0; s < SHARES; s++) begin
          shift_q[s] <= shift_q[s] >> 4;
        end
      end

      if (accept) begin
        cnt_q <= '0;
        for (int s = 0; s < SHARES; s++) begin
          shift_q[s] <= share_in[s];
          res_q[s]   <= '0;
        end
      end
    end
  end

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  // S-box inputs come straight from the shift registers, gated to zero
  // outside feed cycles so nothing leaks while idle or draining.
  assign sbox.sbox_in_s0 = feeding ? shift_q[0][3:0] : 4'h0;
  assign sbox.sbox_in_s1 = feeding ? shift_q[1][3:0] : 4'h0;
  assign sbox.sbox_in_s2 = feeding ? shift_q[2][3:0] : 4'h0;
  assign sbox.sbox_in_s3 = feeding ? shift_q[3][3:0] : 4'h0;
  assign sbox.sbox_in_s4 = feeding ? shift_q[4][3:0] : 4'h0;
  assign sbox.sbox_fresh = feeding ? rnd_in : 40'h0;

  assign result_s0 = res_q[0];
  assign result_s1 = res_q[1];
  assign result_s2 = res_q[2];
  assign result_s3 = res_q[3];
  assign result_s4 = res_q[4];

  assign busy = (state_q != IDLE);

endmodule

// File: doc/sbox_layer_ctrl_d4.md
SBOX_LAYER_CTRL_D4 -- requirements
Module: sbox_layer_ctrl_d4

Interface
REQ-001 Parameter LATENCY, default 4: clock edges from a nibble presented on sbox_in_s* until its result is valid on sbox_out_s*.
REQ-002 Parameter NIBBLES, default 16: number of 4-bit S-box inputs per 64-bit state.
REQ-003 clk  input  1  single clock; all registers rising-edge.
REQ-004 rst  input  1  reset, asynchronous, active-low.
REQ-005 start  input  1  request to process one 64-bit state; sampled only in IDLE.
REQ-006 state_s0..state_s4  input  64 each  five Boolean shares of the input state; nibble k = bits [4k+3:4k].
REQ-007 rnd_in  input  40  fresh randomness, consumed once per feed cycle.
REQ-008 sbox_in_s0..sbox_in_s4  output  4 each  shares driven to the external masked S-box (order-4 HPC2).
REQ-009 sbox_fresh  output  40  randomness forwarded to the S-box Fresh port.
REQ-010 sbox_out_s0..sbox_out_s4  input  4 each  S-box output shares.
REQ-011 result_s0..result_s4  output  64 each  shares of the substituted state, same nibble order.
REQ-012 busy  output  1  high while a state is in flight.
REQ-013 done  output  1  one-cycle pulse when result_s* is complete.

Function
REQ-014 The FSM SHALL have states IDLE, FEED and DRAIN.
REQ-015 IDLE with start=1 at edge E0 SHALL load all five input shares into share-wise shift registers, clear result_s* to zero, set busy, and enter FEED.
REQ-016 FEED SHALL last NIBBLES cycles; in feed cycle j (between edges Ej and Ej+1), sbox_in_s* SHALL equal nibble j of the loaded shares, taken directly from registers.
REQ-017 In FEED, sbox_fresh SHALL equal rnd_in; outside FEED, sbox_fresh and sbox_in_s* SHALL be all-zero.
REQ-018 A 5-bit feed counter SHALL step 0..NIBBLES-1, and the FSM SHALL move to DRAIN at the edge ending feed cycle NIBBLES-1, with no wrap into a second pass.
REQ-019 A LATENCY-deep valid/index pipeline SHALL track each fed nibble.
REQ-020 At edge E(j+LATENCY+1), sbox_out_s* SHALL be written into nibble j of result_s*, share for share, with no share recombination.
REQ-021 DRAIN SHALL last until the capture of nibble NIBBLES-1 at edge E(NIBBLES+LATENCY), which is E20 with defaults; at that edge busy SHALL clear, done SHALL set, and the FSM SHALL return to IDLE.
REQ-022 done SHALL be high for exactly one cycle (cycle 20 with defaults), and result_s* SHALL remain stable until the next accepted start.
REQ-023 start while busy SHALL be ignored, with no effect on the counter, shift registers or result_s*.
REQ-024 start asserted in the same cycle as done SHALL be accepted, because the FSM is already in IDLE there; in that case result_s* is cleared at that edge.
REQ-025 Shares SHALL never be XORed together anywhere in the block.

Reset
REQ-026 rst=0 SHALL asynchronously force IDLE and clear busy, done, the counter, the valid pipeline, the input shift registers and result_s* to zero.
REQ-027 Assertion of rst mid-FEED or mid-DRAIN SHALL abort the operation with no done pulse.
REQ-028 After rst is released, the block SHALL need a fresh start before it produces any output.

Verification
REQ-029 Bench SHALL pair the block with a behavioural 5-share Skinny-64 S-box of latency 4; LATENCY=4, NIBBLES=16.
REQ-030 State 0x0 with random s1..s4 and s0 = XOR of s1..s4 -> done exactly 20 cycles after the start edge; XOR of result shares = 0xCCCCCCCCCCCCCCCC.
REQ-031 State 0x0123456789ABCDEF, randomly shared -> recombined result 0xC6901A2B385D4E7F; busy high for exactly cycles 0..19.
REQ-032 start pulsed again at cycles 5 and 19 -> ignored, with a single done pulse at cycle 20.
REQ-033 rst asserted at cycle 10 -> busy=0 and result_s*=0 immediately; no done pulse; a following start then yields a correct result.
REQ-034 Back-to-back operation, with start held high through the cycle in which done is high -> second result correct, second done 20 cycles after the acceptance edge.
REQ-035 rnd_in counter pattern -> sbox_fresh equals rnd_in only in feed cycles 0..15 and is 0 otherwise; sbox_in_s* is 0 in IDLE and DRAIN.
